// File: rtl/gsim_band_mult.sv
// gsim_band_mult: forward model for the Gauss-Seidel solver.
// Receives an N-word solution vector x (signed Q(XW-FRAC).FRAC) and streams
// b = A*x as rounded, saturated BW-bit signed integers. A is the fixed banded
// matrix: diagonal 20, +-1 -> -13, +-2 -> +6, +-3 -> -1; out-of-range taps are 0.
//
// Ports:
//   clk      clock
//   reset    synchronous, active-high reset
//   x_valid  x_in valid this cycle
//   x_in     solution word, index order 0..N-1
//   b_valid  b_out valid this cycle
//   b_out    recomputed b word, index order 0..N-1 (holds while b_valid=0)
//   b_last   high with the final b_valid of a frame
//   busy     high while computing/draining; x input is not accepted
//   x_drop   one-cycle pulse: x_valid arrived while busy
module gsim_band_mult #(
    parameter int unsigned N    = 16,
    parameter int unsigned XW   = 32,
    parameter int unsigned FRAC = 16,
    parameter int unsigned BW   = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          x_valid,
    input  logic [XW-1:0] x_in,
    output logic          b_valid,
    output logic [BW-1:0] b_out,
    output logic          b_last,
    output logic          busy,
    output logic          x_drop
);

    localparam int unsigned CW = $clog2(N);
    localparam int unsigned EW = $clog2(N + 6);
    localparam int unsigned AW = XW + 8;

    localparam logic [CW-1:0] LastIdx = CW'(N - 1);

    localparam logic signed [AW-1:0] Half =
        {{(AW - FRAC){1'b0}}, 1'b1, {(FRAC - 1){1'b0}}};
    localparam logic signed [AW-1:0] BMax = {{(AW - BW + 1){1'b0}}, {(BW - 1){1'b1}}};
    localparam logic signed [AW-1:0] BMin = {{(AW - BW + 1){1'b1}}, {(BW - 1){1'b0}}};

    typedef enum logic [1:0] {StRecv, StCalc, StDrain} state_e;

    state_e state_q, state_d;

    logic [CW-1:0]        wr_cnt_q;
    logic [CW-1:0]        rd_cnt_q;
    logic                 drain_q;
    logic signed [XW-1:0] xbuf_q [N];

    logic accept;
    logic issue;

    // Pipeline registers
    logic                 v1_q, v2_q, l1_q, l2_q;
    logic signed [XW-1:0] xc_q;
    logic signed [XW:0]   s1_q, s2_q, s3_q;
    logic signed [AW-1:0] acc_q;
    logic                 b_valid_q, b_last_q, x_drop_q;
    logic [BW-1:0]        b_out_q;

    // ------------------------------------------------------------------
    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StRecv;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRecv:  if (x_valid && (wr_cnt_q == LastIdx)) state_d = StCalc;
            StCalc:  if (rd_cnt_q == LastIdx) state_d = StDrain;
            StDrain: if (drain_q) state_d = StRecv;
            default: state_d = StRecv;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy   = (state_q != StRecv);
        accept = x_valid && (state_q == StRecv);
        issue  = (state_q == StCalc);
    end

    // ------------------------------------------------------------------
    // Stage 1 combinational taps: a zero-padded view of the buffer so the
    // band edges need no special cases.
    logic signed [XW-1:0] ext [N + 6];
    logic [EW-1:0]        idx;
    logic signed [XW-1:0] xc_d;
    logic signed [XW:0]   s1_d, s2_d, s3_d;

    always_comb begin
        for (int k = 0; k < N + 6; k++) begin
            ext[k] = '0;
        end
        for (int k = 0; k < N; k++) begin
            ext[k + 3] = xbuf_q[k];
        end
        idx  = EW'(rd_cnt_q) + EW'(3);
        xc_d = ext[idx];
        s1_d = ext[idx - EW'(1)] + ext[idx + EW'(1)];
        s2_d = ext[idx - EW'(2)] + ext[idx + EW'(2)];
        s3_d = ext[idx - EW'(3)] + ext[idx + EW'(3)];
    end

    // Stage 2 combinational: 20*xc - 13*s1 + 6*s2 - s3 via shift-adds.
    logic signed [AW-1:0] xce, s1e, s2e, s3e, acc_d;

    always_comb begin
        xce   = {{(AW - XW){xc_q[XW-1]}}, xc_q};
        s1e   = {{(AW - XW - 1){s1_q[XW]}}, s1_q};
        s2e   = {{(AW - XW - 1){s2_q[XW]}}, s2_q};
        s3e   = {{(AW - XW - 1){s3_q[XW]}}, s3_q};
        acc_d = (xce <<< 4) + (xce <<< 2)
              - ((s1e <<< 3) + (s1e <<< 2) + s1e)
              + (s2e <<< 2) + (s2e <<< 1)
              - s3e;
    end

    // Output stage combinational: round half toward +inf, then saturate.
    logic signed [AW-1:0] rnd, r;
    logic [BW-1:0]        sat;

    always_comb begin
        rnd = acc_q + Half;
        r   = rnd >>> FRAC;
        if (r > BMax) begin
            sat = {1'b0, {(BW - 1){1'b1}}};
        end else if (r < BMin) begin
            sat = {1'b1, {(BW - 1){1'b0}}};
        end else begin
            sat = r[BW-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Datapath and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            drain_q   <= 1'b0;
            for (int k = 0; k < N; k++) begin
                xbuf_q[k] <= '0;
            end
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            l1_q      <= 1'b0;
            l2_q      <= 1'b0;
            xc_q      <= '0;
            s1_q      <= '0;
            s2_q      <= '0;
            s3_q      <= '0;
            acc_q     <= '0;
            b_valid_q <= 1'b0;
            b_last_q  <= 1'b0;
            b_out_q   <= '0;
            x_drop_q  <= 1'b0;
        end else begin
            if (accept) begin
                xbuf_q[wr_cnt_q] <= x_in;
                wr_cnt_q         <= (wr_cnt_q == LastIdx) ? '0 : wr_cnt_q + 1'b1;
            end
            if (issue) begin
                rd_cnt_q <= (rd_cnt_q == LastIdx) ? '0 : rd_cnt_q + 1'b1;
            end
            // Counts the two drain cycles; idles at 0 outside DRAIN.
            drain_q <= (state_q == StDrain) ? ~drain_q : 1'b0;

            v1_q <= issue;
            l1_q <= issue && (rd_cnt_q == LastIdx);
            xc_q <= xc_d;
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;

            v2_q  <= v1_q;
            l2_q  <= l1_q;
            acc_q <= acc_d;

            b_valid_q <= v2_q;
            b_last_q  <= l2_q;
            if (v2_q) begin
                b_out_q <= sat;
            end

            x_drop_q <= x_valid && busy;
        end
    end

    assign b_valid = b_valid_q;
    assign b_last  = b_last_q;
    assign b_out   = b_out_q;
    assign x_drop  = x_drop_q;

endmodule

// File: tb/tb_gsim_band_mult.sv
module tb_gsim_band_mult;

    localparam int N    = 16;
    localparam int XW   = 32;
    localparam int FRAC = 16;
    localparam int BW   = 16;
    localparam int NONE = 99;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          x_valid = 1'b0;
    logic [XW-1:0] x_in = '0;
    logic          b_valid;
    logic [BW-1:0] b_out;
    logic          b_last;
    logic          busy;
    logic          x_drop;

    gsim_band_mult #(
        .N   (N),
        .XW  (XW),
        .FRAC(FRAC),
        .BW  (BW)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .x_valid(x_valid),
        .x_in   (x_in),
        .b_valid(b_valid),
        .b_out  (b_out),
        .b_last (b_last),
        .busy   (busy),
        .x_drop (x_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0][XW-1:0] x;
        logic [N-1:0][BW-1:0] b;
        bit                   gaps;
        int                   drop_at;
    } vec_t;

    vec_t tbl[9];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive count words of vector v, inserting idle cycles when gaps is set.
    task automatic send_frame(input int v, input int count);
        int g;
        for (int w = 0; w < count; w++) begin
            g = tbl[v].gaps ? int'($urandom_range(0, 2)) : 0;
            for (int j = 0; j < g; j++) begin
                @(negedge clk);
                chk($sformatf("v%0d_gap_no_b", v), 32'(b_valid), 32'd0);
                x_valid = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("v%0d_send_no_b", v), 32'(b_valid), 32'd0);
            x_valid = 1'b1;
            x_in    = tbl[v].x[w];
        end
    endtask

    // Sample after each edge E0..E(N+2) following the final accept.
    task automatic collect(input int v);
        int d;
        d = tbl[v].drop_at;
        for (int k = 0; k <= N + 2; k++) begin
            @(negedge clk);
            chk($sformatf("v%0d_busy_e%0d", v, k), 32'(busy), 32'(k < N + 2));
            chk($sformatf("v%0d_valid_e%0d", v, k), 32'(b_valid), 32'(k >= 3));
            chk($sformatf("v%0d_drop_e%0d", v, k), 32'(x_drop), 32'(k == d + 1));
            if (k >= 3) begin
                chk($sformatf("v%0d_b%0d", v, k - 3), 32'(b_out), 32'(tbl[v].b[k-3]));
                chk($sformatf("v%0d_last_e%0d", v, k), 32'(b_last), 32'(k == N + 2));
            end
            x_valid = (k == d);
            x_in    = 32'h7FFF_0000;
        end
        @(negedge clk);
        chk($sformatf("v%0d_valid_after", v), 32'(b_valid), 32'd0);
        chk($sformatf("v%0d_last_after", v), 32'(b_last), 32'd0);
    endtask

    task automatic run_frame(input int v);
        send_frame(v, N);
        collect(v);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        for (int v = 0; v < 9; v++) begin
            tbl[v].x       = '0;
            tbl[v].b       = '0;
            tbl[v].gaps    = 1'b0;
            tbl[v].drop_at = NONE;
        end
        // v1: unit impulse at index 0
        tbl[1].x[0] = 32'h0001_0000;
        tbl[1].b[0] = 16'(20);
        tbl[1].b[1] = 16'(-13);
        tbl[1].b[2] = 16'(6);
        tbl[1].b[3] = 16'(-1);
        // v2: unit impulse at index 7
        tbl[2].x[7]  = 32'h0001_0000;
        tbl[2].b[4]  = 16'(-1);
        tbl[2].b[5]  = 16'(6);
        tbl[2].b[6]  = 16'(-13);
        tbl[2].b[7]  = 16'(20);
        tbl[2].b[8]  = 16'(-13);
        tbl[2].b[9]  = 16'(6);
        tbl[2].b[10] = 16'(-1);
        // v3: all ones
        for (int i = 0; i < N; i++) begin
            tbl[3].x[i] = 32'h0001_0000;
            tbl[3].b[i] = 16'(4);
        end
        tbl[3].b[0]  = 16'(12);
        tbl[3].b[1]  = 16'(-1);
        tbl[3].b[2]  = 16'(5);
        tbl[3].b[13] = 16'(5);
        tbl[3].b[14] = 16'(-1);
        tbl[3].b[15] = 16'(12);
        // v4: 0.5 at index 0 -> rounding half toward +inf
        tbl[4].x[0] = 32'h0000_8000;
        tbl[4].b[0] = 16'(10);
        tbl[4].b[1] = 16'(-6);
        tbl[4].b[2] = 16'(3);
        tbl[4].b[3] = 16'(0);
        // v5: near full-scale at index 0 -> saturation
        tbl[5].x[0] = 32'h7FFF_0000;
        tbl[5].b[0] = 16'(32767);
        tbl[5].b[1] = 16'(-32768);
        tbl[5].b[2] = 16'(32767);
        tbl[5].b[3] = 16'(-32767);
        // v6: -1.0 at the last index
        tbl[6].x[15] = 32'hFFFF_0000;
        tbl[6].b[15] = 16'(-20);
        tbl[6].b[14] = 16'(13);
        tbl[6].b[13] = 16'(-6);
        tbl[6].b[12] = 16'(1);
        // v7: all ones with input gaps and a dropped word mid-calculation
        tbl[7]         = tbl[3];
        tbl[7].gaps    = 1'b1;
        tbl[7].drop_at = 5;
        // v8: impulse, word arriving on the cycle busy falls is dropped
        tbl[8]         = tbl[1];
        tbl[8].drop_at = N + 1;

        // Reset state
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_b_valid", 32'(b_valid), 32'd0);
        chk("rst_b_out", 32'(b_out), 32'd0);
        chk("rst_b_last", 32'(b_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_x_drop", 32'(x_drop), 32'd0);
        reset = 1'b0;

        for (int v = 0; v < 9; v++) begin
            run_frame(v);
        end

        // Reset after 8 accepted words, then a clean frame of ones.
        send_frame(5, 8);
        @(negedge clk);
        x_valid = 1'b0;
        reset   = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(b_valid), 32'd0);
        reset = 1'b0;
        run_frame(3);

        // Reset while results are in flight: nothing may emerge afterwards.
        send_frame(1, N);
        @(negedge clk);
        x_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < N + 4; k++) begin
            @(negedge clk);
            chk($sformatf("flight_valid_%0d", k), 32'(b_valid), 32'd0);
            chk($sformatf("flight_busy_%0d", k), 32'(busy), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
